// File: rtl/uart_cmd_initiator.sv
// uart_cmd_initiator: host-side initiator for the PSRAM UART command responder.
// Serialises a read ('R' + 3 address bytes) or write ('W' + 3 address bytes +
// 2 data bytes) request as back-to-back 8N1 frames. For a read, it then
// receives the 2-byte reply and returns it as a 16-bit word.
module uart_cmd_initiator #(
    parameter int DELAY_FRAMES = 234,
    parameter int RSP_TIMEOUT  = 2_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [22:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int CNT_W = $clog2(DELAY_FRAMES + 1);
    localparam int TO_W  = $clog2(RSP_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DELAY_FRAMES / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RSP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP,
        S_RX_WAIT,
        S_RX_START,
        S_RX_DATA,
        S_RX_STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;        // per-bit cycle counter, shared by TX and RX
    logic [2:0]        bit_idx;    // bit within the current byte
    logic [2:0]        tx_byte;    // byte being transmitted
    logic [2:0]        last_byte;  // index of the final byte of this frame
    logic [47:0]       tx_buf;     // outgoing bytes, byte 0 in [7:0], shifted right per bit
    logic              is_write;
    logic [TO_W-1:0]   tcnt;       // first-byte response timeout counter
    logic              rx_idx;     // 0: waiting for reply byte 0, 1: reply byte 1
    logic [7:0]        rx_shift;
    logic [7:0]        rx_byte0;
    logic              rx_meta;
    logic              rx_sync;

    // Double-flop synchroniser for the asynchronous serial input; resets to idle-high.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Main command FSM: accept, serialise the request, then receive the reply for reads.
    // NOTE: every register here is assigned with <= so all reads see the pre-edge
    // value; mixing in = would make results depend on statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            tx_byte     <= '0;
            last_byte   <= '0;
            tx_buf      <= '0;
            is_write    <= 1'b0;
            tcnt        <= '0;
            rx_idx      <= 1'b0;
            rx_shift    <= '0;
            rx_byte0    <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            uart_tx     <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            // NOTE: single-cycle pulses default low each cycle and are raised only
            // in the branch that produces them.
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        is_write <= cmd_write;
                        if (cmd_write) begin
                            tx_buf    <= {cmd_wdata[15:8], cmd_wdata[7:0],
                                          1'b0, cmd_addr[22:16], cmd_addr[15:8],
                                          cmd_addr[7:0], 8'h57};
                            last_byte <= 3'd5;
                        end else begin
                            tx_buf    <= {16'h0000, cmd_addr[7:0], cmd_addr[15:8],
                                          1'b0, cmd_addr[22:16], 8'h52};
                            last_byte <= 3'd3;
                        end
                        tx_byte   <= '0;
                        cnt       <= '0;
                        uart_tx   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_TX_START;
                    end
                end

                S_TX_START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        uart_tx <= tx_buf[0];
                        tx_buf  <= tx_buf >> 1;
                        state   <= S_TX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_TX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= S_TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            uart_tx <= tx_buf[0];
                            tx_buf  <= tx_buf >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_TX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (tx_byte != last_byte) begin
                            // Next byte follows immediately with no idle gap.
                            tx_byte <= tx_byte + 1'b1;
                            uart_tx <= 1'b0;
                            state   <= S_TX_START;
                        end else if (is_write) begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            tcnt   <= '0;
                            rx_idx <= 1'b0;
                            state  <= S_RX_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RX_WAIT: begin
                    if (!rx_sync) begin
                        cnt   <= '0;
                        state <= S_RX_START;
                    end else if (!rx_idx) begin
                        // Timeout guards only the first reply byte.
                        if (tcnt == TO_LAST) begin
                            rsp_timeout <= 1'b1;
                            cmd_ready   <= 1'b1;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end

                S_RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            // Line went back high by mid-start: treat as a glitch.
                            state <= S_RX_WAIT;
                        end else begin
                            bit_idx <= '0;
                            state   <= S_RX_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            // Framing error: drop the byte and hunt for a new start bit.
                            state <= S_RX_WAIT;
                        end else if (!rx_idx) begin
                            rx_byte0 <= rx_shift;
                            rx_idx   <= 1'b1;
                            state    <= S_RX_WAIT;
                        end else begin
                            rsp_data  <= {rx_shift, rx_byte0};
                            rsp_valid <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Self-checking bench for uart_cmd_initiator: decodes uart_tx against a queue
// of expected bytes, plays the responder on uart_rx, and scores read replies
// and timeouts against a queue of expected response words.
module tb_uart_cmd_initiator;

    localparam int D  = 8;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [22:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        uart_tx;
    logic        uart_rx;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rsp_pulses = 0;
    int          to_pulses  = 0;
    int          to_cyc     = 0;
    logic [7:0]  exp_tx_q[$];
    logic [15:0] exp_rsp_q[$];

    uart_cmd_initiator #(
        .DELAY_FRAMES(D),
        .RSP_TIMEOUT (TO)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (sys_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .uart_tx    (uart_tx),
        .uart_rx    (uart_rx),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // UART decoder on uart_tx; bytes interrupted by reset are discarded.
    initial begin : tx_monitor
        logic [7:0] b;
        bit         abort;
        forever begin
            @(negedge clk);
            if (sys_rst_n === 1'b1 && uart_tx === 1'b0) begin
                abort = 1'b0;
                repeat (D / 2) begin @(negedge clk); if (sys_rst_n !== 1'b1) abort = 1'b1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (D) begin @(negedge clk); if (sys_rst_n !== 1'b1) abort = 1'b1; end
                    b[i] = uart_tx;
                end
                repeat (D) begin @(negedge clk); if (sys_rst_n !== 1'b1) abort = 1'b1; end
                if (!abort) begin
                    check("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
                    check("tx_byte_expected", {31'd0, exp_tx_q.size() != 0}, 32'd1);
                    if (exp_tx_q.size() != 0) check("tx_byte", {24'd0, b}, {24'd0, exp_tx_q.pop_front()});
                end
            end
        end
    end

    // Response monitor: scores rsp_valid data, records timeout pulses.
    initial begin : rsp_monitor
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || rsp_timeout === 1'b1)
                check("rsp_exclusive", {31'd0, rsp_valid & rsp_timeout}, 32'd0);
            if (rsp_valid === 1'b1) begin
                rsp_pulses++;
                check("rsp_expected", {31'd0, exp_rsp_q.size() != 0}, 32'd1);
                if (exp_rsp_q.size() != 0) check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_rsp_q.pop_front()});
            end
            if (rsp_timeout === 1'b1) begin
                to_pulses++;
                to_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got cycle limit expected bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_cmd(input bit wr, input logic [22:0] addr, input logic [15:0] wd,
                            output int acc_cyc);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 5000) begin @(posedge clk); #1; guard++; end
        check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
        if (wr) begin
            exp_tx_q.push_back(8'h57);
            exp_tx_q.push_back(addr[7:0]);
            exp_tx_q.push_back(addr[15:8]);
            exp_tx_q.push_back({1'b0, addr[22:16]});
            exp_tx_q.push_back(wd[7:0]);
            exp_tx_q.push_back(wd[15:8]);
        end else begin
            exp_tx_q.push_back(8'h52);
            exp_tx_q.push_back({1'b0, addr[22:16]});
            exp_tx_q.push_back(addr[15:8]);
            exp_tx_q.push_back(addr[7:0]);
        end
    endtask

    // Returns just after the edge on which the last stop bit ends.
    task automatic wait_frame_end(input int acc_cyc, input int nbytes);
        while (cyc < acc_cyc + nbytes * 10 * D) begin @(posedge clk); #1; end
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        repeat (D) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (D) @(posedge clk);
            #1;
        end
        uart_rx = stop_ok;
        repeat (D) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Checks that a read reply has completed and the block is back in IDLE.
    task automatic check_read_done(input string tag, input int pulses_before);
        idle(4);
        check({tag, "_rsp_pulse_count"}, rsp_pulses - pulses_before, 1);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin : main
        int acc;
        int n_busy;
        int p0;
        int t0;

        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        uart_rx   = 1'b1;
        idle(3);

        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("reset_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        sys_rst_n = 1'b1;
        idle(2);

        // Write frame, with a second request held while busy.
        p0 = rsp_pulses;
        t0 = to_pulses;
        send_cmd(1'b1, 23'h1ABCDE, 16'hBEEF, acc);
        check("wr_busy_after_accept", {31'd0, busy}, 32'd1);
        check("wr_start_bit", {31'd0, uart_tx}, 32'd0);
        check("wr_ready_low", {31'd0, cmd_ready}, 32'd0);
        n_busy = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n_busy++;
            if (n_busy == 20) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b0;
                cmd_addr  = 23'h7FFFFF;
            end
            if (n_busy == 25) check("busy_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            if (n_busy == 30) cmd_valid = 1'b0;
        end
        check("wr_busy_cycles", n_busy, 6 * 10 * D);
        check("wr_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        check("wr_frame_consumed", exp_tx_q.size(), 0);
        idle(50);
        check("wr_no_rsp", rsp_pulses - p0, 0);
        check("wr_no_timeout", to_pulses - t0, 0);

        // Read with a clean reply.
        p0 = rsp_pulses;
        send_cmd(1'b0, 23'h1ABCDE, 16'h0000, acc);
        wait_frame_end(acc, 4);
        check("rd_frame_consumed", exp_tx_q.size(), 0);
        idle(2);
        exp_rsp_q.push_back(16'h1234);
        rx_byte(8'h34, 1'b1);
        rx_byte(8'h12, 1'b1);
        check_read_done("rd", p0);

        // Read with no reply: timeout.
        p0 = rsp_pulses;
        t0 = to_pulses;
        send_cmd(1'b0, 23'h000123, 16'h0000, acc);
        idle(4 * 10 * D + TO + 20);
        check("to_pulse_count", to_pulses - t0, 1);
        check("to_latency", to_cyc - acc, 4 * 10 * D + TO);
        check("to_no_rsp", rsp_pulses - p0, 0);
        check("to_rsp_data_held", {16'd0, rsp_data}, 32'h1234);
        check("to_busy_low", {31'd0, busy}, 32'd0);
        check("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Read with a framing error on the first reply byte.
        p0 = rsp_pulses;
        send_cmd(1'b0, 23'h00F00D, 16'h0000, acc);
        wait_frame_end(acc, 4);
        idle(2);
        exp_rsp_q.push_back(16'hAA55);
        rx_byte(8'h77, 1'b0);
        idle(2 * D);
        rx_byte(8'h55, 1'b1);
        rx_byte(8'hAA, 1'b1);
        check_read_done("frm", p0);

        // Read with a short low glitch before the reply.
        p0 = rsp_pulses;
        send_cmd(1'b0, 23'h654321, 16'h0000, acc);
        wait_frame_end(acc, 4);
        idle(3);
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(2 * D);
        exp_rsp_q.push_back(16'h5AC3);
        rx_byte(8'hC3, 1'b1);
        rx_byte(8'h5A, 1'b1);
        check_read_done("glitch", p0);

        // Reset in the middle of a write frame, then a normal read.
        send_cmd(1'b1, 23'h012345, 16'h6789, acc);
        while (cyc < acc + 10 * D + 3) begin @(posedge clk); #1; end
        check("rst_tx_low_before", {31'd0, uart_tx}, 32'd0);
        sys_rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_mid_rsp_data", {16'd0, rsp_data}, 32'd0);
        sys_rst_n = 1'b1;
        exp_tx_q.delete();
        idle(15 * D);
        p0 = rsp_pulses;
        send_cmd(1'b0, 23'h0055AA, 16'h0000, acc);
        wait_frame_end(acc, 4);
        idle(2);
        exp_rsp_q.push_back(16'hBC9A);
        rx_byte(8'h9A, 1'b1);
        rx_byte(8'hBC, 1'b1);
        check_read_done("post_rst", p0);

        idle(20);
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("rsp_queue_drained", exp_rsp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_initiator.md
Name: uart_cmd_initiator

Overview:
- Host-side counterpart of the PSRAM UART command responder.
- Accepts one read or write request on a valid/ready handshake and serialises it as an 8N1 UART frame: 'R'+3 address bytes, or 'W'+3 address bytes+2 data bytes.
- For reads, it then receives the responder's 2-byte reply on uart_rx and returns it as a 16-bit word.
- Used for board-to-board links and as the self-checking stimulus engine in loopback tests.

Parameters:
- DELAY_FRAMES, 234, sys_clk cycles per UART bit (27 MHz / 115200).
- RSP_TIMEOUT, 2_000_000, cycles to wait for the first response start bit before aborting a read.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  synchronous reset, active-low.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  high only in IDLE; transfer occurs when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  23  PSRAM address.
- cmd_wdata  input  16  write data; ignored for reads.
- uart_tx  output  1  serial out; idles high.
- uart_rx  input  1  serial in; idles high.
- rsp_valid  output  1  one-cycle pulse carrying read data.
- rsp_data  output  16  read data; holds until the next rsp_valid.
- rsp_timeout  output  1  one-cycle pulse when a read is aborted.
- busy  output  1  high from accept until return to IDLE.

Behaviour:
- Reset values: cmd_ready=1 (IDLE), uart_tx=1, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0; all counters 0. Reset mid-frame forces uart_tx=1 on the next edge and drops the request; no partial-frame recovery.
- Accept (IDLE, valid&&ready): register cmd_write, cmd_addr, cmd_wdata. Build the byte buffer; byte count is 4 for a read, 6 for a write. busy rises next cycle. First start bit drives uart_tx one cycle after accept.
- Read frame: 0x52, {1'b0,addr[22:16]}, addr[15:8], addr[7:0]. Address is sent MSB byte first.
- Write frame: 0x57, addr[7:0], addr[15:8], {1'b0,addr[22:16]}, wdata[7:0], wdata[15:8]. Address and data are sent LSB byte first.
- TX states: TX_START (uart_tx=0), TX_DATA (8 bits, LSB first), TX_STOP (uart_tx=1).
  - Each state lasts exactly DELAY_FRAMES cycles.
  - Bytes are sent back-to-back with no idle gap.
  - Frame duration = nbytes*10*DELAY_FRAMES cycles.
- After the last stop bit:
  - Write: return to IDLE; cmd_ready=1 on the following cycle. No response is expected.
  - Read: go to RX_WAIT.
- RX_WAIT: the timeout counter starts at 0 and increments each cycle.
  - If uart_rx is sampled low, go to RX_START.
  - If the count reaches RSP_TIMEOUT-1 first, pulse rsp_timeout and go to IDLE.
  - The timeout applies only before the first response byte.
- RX_START: wait DELAY_FRAMES/2 cycles, then re-sample.
  - High: glitch; return to RX_WAIT. The timeout counter is not reset.
  - Low: go to RX_DATA.
- RX_DATA: sample every DELAY_FRAMES cycles, 8 samples, shifting in LSB first.
- RX_STOP: sample once after DELAY_FRAMES cycles.
  - High: byte accepted.
  - Low (framing error): byte discarded; return to RX_WAIT without advancing the byte index.
- Byte 0 → rsp_data[7:0]; byte 1 → rsp_data[15:8].
- After byte 1 is accepted: update rsp_data and pulse rsp_valid in the same cycle, then go to IDLE.
- Second-byte wait: the second byte uses the RX_WAIT detection path but with no timeout. A stalled responder keeps busy=1 until reset.
- uart_rx: double-flop synchronised before use. Its latency is already included in the sample points.
- uart_rx activity during IDLE or TX states is ignored.
- cmd_valid during busy is ignored; cmd_ready=0.
- rsp_valid and rsp_timeout are never high together.

Test Plan:
- Write (DELAY_FRAMES=8): addr=0x1ABCDE, wdata=0xBEEF → uart_tx decodes 57 DE BC 1A EF BE; busy for 480 cycles; no rsp pulses; cmd_ready returns.
- Read with loopback model replying 0x34 then 0x12 → tx shows 52 1A BC DE for addr=0x1ABCDE; rsp_valid single pulse; rsp_data=0x1234.
- Read, no reply, RSP_TIMEOUT=100 → rsp_timeout pulses exactly 100 cycles after the final stop bit ends; rsp_data unchanged; IDLE.
- Read, reply byte 0 with stop bit forced low, then valid bytes 0x55, 0xAA → bad byte dropped; rsp_data=0xAA55.
- 2-cycle low glitch on uart_rx in RX_WAIT, then valid reply → glitch ignored; correct data.
- sys_rst_n low mid-byte during a write → uart_tx=1 next cycle; busy=0; cmd_ready=1; a new read completes normally afterwards.
